// File: rtl/ysyx_22040386_dmem_resp_if.sv
// Load/store request and response channel between the data-memory initiator and the responder.
// The master end issues requests and accepts responses; the slave end serves them.
interface ysyx_22040386_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22040386_dmem_resp.sv
// Data-memory responder: serves one load/store at a time from an on-chip 64-bit word array
// after a fixed programmable latency, with per-byte store masks and out-of-range error flagging.
module ysyx_22040386_dmem_resp #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22040386_dmem_resp_if.slave   bus
);

    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;

    logic          r_wen;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [7:0]    r_wmask;

    logic [63:0]   r_rdata;
    logic          r_err;

    logic [63:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic [63:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_in_range;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_commit = (r_state == BUSY) && (r_cnt == '0);

    // Addresses below BASE wrap in the subtraction, so the lower bound is checked separately.
    assign w_off      = r_addr - BASE;
    assign w_idx      = w_off[AW+2:3];
    assign w_in_range = (r_addr >= BASE) && ((w_off >> 3) < 64'(DEPTH));

    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_wen   <= bus.req_wen;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_wmask <= bus.req_wmask;
                r_cnt   <= CW'(LATENCY - 1);
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_commit) begin
                r_rdata <= (!r_wen && w_in_range) ? r_mem[w_idx] : '0;
                r_err   <= !w_in_range;
            end else if ((r_state == RESP) && bus.rsp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Array has no reset; contents survive rst and are undefined after power-up.
    always_ff @(posedge clk) begin
        if (w_commit && r_wen && w_in_range) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (r_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_ysyx_22040386_dmem_resp.sv
// Directed bench for the data-memory responder: one LATENCY=2 instance for the main
// scenarios and one LATENCY=4 instance for the reset-during-BUSY case.
module tb_ysyx_22040386_dmem_resp;

    logic clk;
    logic rst2;
    logic rst4;
    int   checks;
    int   failures;

    ysyx_22040386_dmem_resp_if d2 ();
    ysyx_22040386_dmem_resp_if d4 ();

    ysyx_22040386_dmem_resp #(.DEPTH(256), .LATENCY(2), .BASE(64'h8000_0000)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (d2.slave)
    );

    ysyx_22040386_dmem_resp #(.DEPTH(256), .LATENCY(4), .BASE(64'h8000_0000)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (d4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request on the selected instance (caller sits #1 after an edge, DUT idle,
    // rsp_ready high), waits for the response and completes the handshake.
    task automatic xact(input bit use4, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] mask,
                        output int lat, output logic [63:0] rd, output logic er);
        if (use4) begin
            d4.req_valid = 1'b1; d4.req_wen = wen; d4.req_addr = addr;
            d4.req_wdata = wdata; d4.req_wmask = mask;
        end else begin
            d2.req_valid = 1'b1; d2.req_wen = wen; d2.req_addr = addr;
            d2.req_wdata = wdata; d2.req_wmask = mask;
        end
        @(posedge clk); #1;
        if (use4) d4.req_valid = 1'b0; else d2.req_valid = 1'b0;
        lat = 0;
        while (!(use4 ? d4.rsp_valid : d2.rsp_valid) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = use4 ? d4.rsp_rdata : d2.rsp_rdata;
        er = use4 ? d4.rsp_err : d2.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst2 = 1'b1; rst4 = 1'b1;
        #2;
        checks++; if (d2.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", d2.rsp_valid); end
        checks++; if (d2.rsp_rdata !== 64'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", d2.rsp_rdata); end
        checks++; if (d2.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", d2.rsp_err); end
        checks++; if (d2.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready_in_rst got=%b exp=0", d2.req_ready); end
        @(posedge clk); #1;
        rst2 = 1'b0; rst4 = 1'b0;
        @(posedge clk); #1;
        checks++; if (d2.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready_after got=%b exp=1", d2.req_ready); end
        checks++; if (d4.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready4_after got=%b exp=1", d4.req_ready); end
    endtask

    task automatic test_round_trip();
        int lat; logic [63:0] rd; logic er;
        xact(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, lat, rd, er);
        checks++; if (lat !== 2) begin failures++; $display("FAIL rt_store_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL rt_store_err got=%b exp=0", er); end
        checks++; if (rd !== 64'h0) begin failures++; $display("FAIL rt_store_rdata got=%h exp=0", rd); end
        xact(0, 1'b0, 64'h8000_0013, 64'h0, 8'h00, lat, rd, er);
        checks++; if (lat !== 2) begin failures++; $display("FAIL rt_load_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL rt_load_rdata got=%h exp=1122334455667788", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL rt_load_err got=%b exp=0", er); end
    endtask

    task automatic test_byte_mask();
        int lat; logic [63:0] rd; logic er;
        xact(0, 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0C, lat, rd, er);
        xact(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er);
        checks++; if (rd !== 64'h1122_3344_AAAA_7788) begin failures++; $display("FAIL mask_0c_rdata got=%h exp=11223344aaaa7788", rd); end
        xact(0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, lat, rd, er);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL mask_zero_err got=%b exp=0", er); end
        xact(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er);
        checks++; if (rd !== 64'h1122_3344_AAAA_7788) begin failures++; $display("FAIL mask_zero_rdata got=%h exp=11223344aaaa7788", rd); end
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] rd; logic er; int n;
        d2.rsp_ready = 1'b0;
        d2.req_valid = 1'b1; d2.req_wen = 1'b0; d2.req_addr = 64'h8000_0010;
        d2.req_wdata = 64'h0; d2.req_wmask = 8'h00;
        @(posedge clk); #1;
        // Pending store presented while busy; also changes inputs after the accept edge.
        d2.req_wen = 1'b1; d2.req_addr = 64'h8000_0018;
        d2.req_wdata = 64'h5555_6666_7777_8888; d2.req_wmask = 8'hFF;
        n = 0;
        while (!d2.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", n); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (d2.rsp_valid !== 1'b1 || d2.rsp_rdata !== 64'h1122_3344_AAAA_7788 || d2.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h ready=%b exp valid=1 rdata=11223344aaaa7788 ready=0",
                         c, d2.rsp_valid, d2.rsp_rdata, d2.req_ready);
            end
            @(posedge clk); #1;
        end
        d2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (d2.rsp_valid !== 1'b0 || d2.req_ready !== 1'b1) begin failures++; $display("FAIL bp_idle valid=%b ready=%b exp valid=0 ready=1", d2.rsp_valid, d2.req_ready); end
        @(posedge clk); #1;
        checks++; if (d2.req_ready !== 1'b0) begin failures++; $display("FAIL bp_pending_accept ready=%b exp=0", d2.req_ready); end
        d2.req_valid = 1'b0;
        n = 0;
        while (!d2.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        xact(0, 1'b0, 64'h8000_0018, 64'h0, 8'h00, lat, rd, er);
        checks++; if (rd !== 64'h5555_6666_7777_8888) begin failures++; $display("FAIL bp_pending_store got=%h exp=5555666677778888", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [63:0] rd; logic er;
        xact(0, 1'b1, 64'h8000_07F8, 64'hCAFE_F00D_1234_5678, 8'hFF, lat, rd, er);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL oor_last_store_err got=%b exp=0", er); end
        xact(0, 1'b1, 64'h8000_0000, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, lat, rd, er);
        xact(0, 1'b1, 64'h8000_0800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, rd, er);
        checks++; if (er !== 1'b1 || rd !== 64'h0) begin failures++; $display("FAIL oor_store_hi err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        xact(0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, lat, rd, er);
        checks++; if (er !== 1'b1 || rd !== 64'h0) begin failures++; $display("FAIL oor_load_lo err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        xact(0, 1'b0, 64'h8000_07F8, 64'h0, 8'h00, lat, rd, er);
        checks++; if (er !== 1'b0 || rd !== 64'hCAFE_F00D_1234_5678) begin failures++; $display("FAIL oor_last_load err=%b rdata=%h exp err=0 rdata=cafef00d12345678", er, rd); end
        xact(0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, lat, rd, er);
        checks++; if (rd !== 64'h0BAD_0BAD_0BAD_0BAD) begin failures++; $display("FAIL oor_word0_intact got=%h exp=0bad0bad0bad0bad", rd); end
    endtask

    task automatic test_async_reset();
        int lat; logic [63:0] rd; logic er; int n;
        d2.rsp_ready = 1'b0;
        d2.req_valid = 1'b1; d2.req_wen = 1'b0; d2.req_addr = 64'h8000_0010;
        @(posedge clk); #1;
        d2.req_valid = 1'b0;
        n = 0;
        while (!d2.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (d2.rsp_rdata !== 64'h1122_3344_AAAA_7788) begin failures++; $display("FAIL arst_pre_rdata got=%h exp=11223344aaaa7788", d2.rsp_rdata); end
        #2 rst2 = 1'b1;
        #1;
        checks++; if (d2.rsp_valid !== 1'b0 || d2.rsp_rdata !== 64'h0 || d2.rsp_err !== 1'b0) begin
            failures++; $display("FAIL arst_outputs valid=%b rdata=%h err=%b exp all 0", d2.rsp_valid, d2.rsp_rdata, d2.rsp_err);
        end
        @(posedge clk); #1;
        rst2 = 1'b0; d2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (d2.req_ready !== 1'b1) begin failures++; $display("FAIL arst_ready_after got=%b exp=1", d2.req_ready); end
        xact(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er);
        checks++; if (rd !== 64'h1122_3344_AAAA_7788) begin failures++; $display("FAIL arst_array_kept got=%h exp=11223344aaaa7788", rd); end
    endtask

    task automatic test_reset_busy();
        int lat; logic [63:0] rd; logic er; bit seen;
        xact(1, 1'b1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rd, er);
        checks++; if (lat !== 4) begin failures++; $display("FAIL rb_latency4 got=%0d exp=4", lat); end
        d4.req_valid = 1'b1; d4.req_wen = 1'b1; d4.req_addr = 64'h8000_0020;
        d4.req_wdata = 64'h0000_0000_DEAD_BEEF; d4.req_wmask = 8'hFF;
        @(posedge clk); #1;
        d4.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (d4.rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rb_no_response seen=%b exp=0", seen); end
        xact(1, 1'b0, 64'h8000_0020, 64'h0, 8'h00, lat, rd, er);
        checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL rb_old_value got=%h exp=0123456789abcdef", rd); end
    endtask

    task automatic test_back_to_back();
        int acc[$]; int n;
        d2.rsp_ready = 1'b1;
        d2.req_valid = 1'b1; d2.req_wen = 1'b0; d2.req_addr = 64'h8000_0010;
        for (int c = 0; c < 12; c++) begin
            if (d2.req_ready && d2.req_valid) acc.push_back(c);
            @(posedge clk); #1;
        end
        d2.req_valid = 1'b0;
        checks++; if (acc.size() !== 3) begin failures++; $display("FAIL b2b_accept_count got=%0d exp=3", acc.size()); end
        checks++; if (acc.size() < 2 || (acc[1] - acc[0]) !== 4) begin
            failures++; $display("FAIL b2b_spacing got=%0d exp=4", (acc.size() < 2) ? -1 : acc[1] - acc[0]);
        end
        n = 0;
        while (!d2.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst2 = 1'b0; rst4 = 1'b0;
        d2.req_valid = 1'b0; d2.req_wen = 1'b0; d2.req_addr = '0; d2.req_wdata = '0; d2.req_wmask = '0; d2.rsp_ready = 1'b1;
        d4.req_valid = 1'b0; d4.req_wen = 1'b0; d4.req_addr = '0; d4.req_wdata = '0; d4.req_wmask = '0; d4.rsp_ready = 1'b1;
        test_reset();
        test_round_trip();
        test_byte_mask();
        test_backpressure();
        test_out_of_range();
        test_async_reset();
        test_reset_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22040386_dmem_resp.md
# ysyx_22040386_dmem_resp

Data-memory responder: the slave end of the core's data-memory load/store path. It accepts one request at a time over a valid/ready channel and serves it from a synthesizable on-chip word array after a programmable latency. Reads return a whole aligned 64-bit word; writes apply a per-byte mask. Byte, half and word lane extraction and sign extension stay with the initiator. The block replaces the DPI `pmem` model wherever a cycle-accurate, synthesizable memory is required.

## Interface
- `DEPTH`, 256: number of 64-bit words in the array.
- `LATENCY`, 2: cycles from request acceptance to `rsp_valid`. Must be ≥ 1.
- `BASE`, 64'h8000_0000: byte address of word 0.

- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_addr`  in  64  byte address. Bits [2:0] are ignored.
- `req_wdata`  in  64  store data, lane-aligned: byte i on bits [8i+7:8i].
- `req_wmask`  in  8  store byte enables. Bit i enables byte i.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts the response.
- `rsp_rdata`  out  64  load data: the aligned word. Always 0 for stores and for errors.
- `rsp_err`  out  1  address out of range. Qualified by `rsp_valid`.

## Operation
- **FSM states:** IDLE, BUSY, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid & req_ready`: latch wen, addr, wdata and wmask; load `cnt` = LATENCY-1; go to BUSY.
- **BUSY**
  - `req_ready` = 0.
  - If `cnt` != 0: decrement `cnt`.
  - If `cnt` == 0: commit the access at this edge and go to RESP.
- **Commit**
  - `off` = addr − BASE, 64-bit unsigned subtraction. `idx` = off >> 3.
  - In range: addr ≥ BASE and idx < DEPTH.
  - Load, in range: `rsp_rdata` ← mem[idx], `rsp_err` ← 0.
  - Store, in range: for each i with wmask[i] = 1, byte i of mem[idx] ← wdata byte i. Other bytes are unchanged. `rsp_rdata` ← 0, `rsp_err` ← 0.
  - Out of range: no array write; `rsp_rdata` ← 0, `rsp_err` ← 1.
  - Store with wmask = 0: legal. Nothing is written and a normal ack is returned.
- **RESP**
  - `rsp_valid` = 1. `rsp_rdata` and `rsp_err` are held stable until the handshake.
  - On `rsp_ready`: go to IDLE.
- **Array**
  - Register array, no reset; contents are undefined after power-up.
  - One write port and one read port. Only one access is ever outstanding.
- **Counter width:** `cnt` is $clog2(LATENCY+1) bits. When LATENCY = 1, `cnt` loads 0.

## Timing
- **Reset values:** `req_ready` = 0 while `rst` is asserted, then 1 in IDLE; `rsp_valid` = 0; `rsp_rdata` = 0; `rsp_err` = 0; `cnt` = 0.
- **Latency**
  - Request accepted at edge E. `rsp_valid` is high from edge E+LATENCY.
  - Throughput, with `rsp_ready` held high: one request per LATENCY+2 cycles.
  - There is always one IDLE bubble after a response handshake. A request held during RESP is accepted the cycle after the response handshake.
- **Ready rules:** `req_ready` depends on state only, never on `req_valid`. `rsp_valid` does not depend on `rsp_ready`.
- **Backpressure:** if `rsp_ready` stays low, the block stays in RESP indefinitely and outputs do not change.
- **Data visibility:** a store commits at the BUSY→RESP edge. A load accepted after that store's response sees the new data.
- **Input stability:** request inputs are sampled only at the accept edge. Later changes are ignored.
- **Reset mid-operation**
  - `rst` during BUSY aborts the request with no array write.
  - `rst` during RESP drops the response.
  - The array holds whatever was committed before reset.
- **Boundary addresses:** BASE+8·(DEPTH−1) is in range. BASE+8·DEPTH and BASE−8 are errors. An address below BASE wraps in the subtraction and must still be flagged as an error.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle with no clock edge. Required: `rsp_valid`, `rsp_rdata` and `rsp_err` go to 0 immediately; `req_ready` = 1 one cycle after release.
- **Store/load round trip, LATENCY = 2.**
  - Store to 0x8000_0010, wdata 0x1122_3344_5566_7788, wmask 0xFF. Required: `rsp_valid` 2 cycles after accept, `rsp_err` = 0.
  - Load from 0x8000_0013. Required: `rsp_rdata` = 0x1122_3344_5566_7788.
- **Byte-masked store.**
  - Word 0x8000_0010 holds 0x1122_3344_5566_7788. Store wdata 0xAAAA_AAAA_AAAA_AAAA, wmask 0x0C.
  - Load the same word. Required: 0x1122_3344_AAAA_7788.
- **Response backpressure.**
  - Hold `rsp_ready` = 0 for 5 cycles on a load. Required: `rsp_valid` and `rsp_rdata` stable throughout; `req_ready` = 0.
  - Raise `rsp_ready`. Required: back in IDLE next cycle; a pending request is accepted the cycle after.
- **Out-of-range accesses.**
  - With DEPTH = 256, store to 0x8000_0800 and load from 0x7FFF_FFF8. Required: `rsp_err` = 1 and `rsp_rdata` = 0 for both.
  - A subsequent load of 0x8000_07F8. Required: `rsp_err` = 0, previous contents unchanged.
- **Reset during BUSY.**
  - Store 0xDEAD_BEEF to 0x8000_0020 with LATENCY = 4. Assert `rst` 2 cycles after accept. Required: no response.
  - Load the same address. Required: old value, not 0xDEAD_BEEF.
